fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control unit.
- Owns the PC and drives the icache request (iREN/imemaddr, completed by ihit).
- Captures returned instructions into an IF/ID register whose instr_o feeds the control unit's imemload.
- Applies PC redirects (JR, J, BNE, BEQ) resolved in decode, squashes wrong-path fetches, honours hazard stall, and stops fetching on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble into IF/ID.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache: instruction at imemaddr is valid this cycle.
- imemload_in  in  32  icache read data.
- iREN  out  1  icache read enable.
- imemaddr  out  32  icache address, always equal to PC.
- stall  in  1  hazard unit: hold IF/ID and PC.
- flush  in  1  downstream flush request: bubble IF/ID.
- PCsrc  in  3  from control unit: 0 npc, 2 JR, 3 J, 4 BNE, 5 BEQ; 1, 6, 7 treated as 0.
- zero  in  1  register-compare equality from decode (rs==rt).
- rdat1  in  32  JR target.
- branch_tgt  in  32  fully formed branch target from decode.
- jaddr  in  26  J instruction index.
- id_halt  in  1  control unit halt for the instruction in IF/ID.
- instr_o  out  32  IF/ID instruction, drives the control unit's imemload.
- npc_o  out  32  IF/ID PC+4.
- valid_o  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch permanently stopped.

Behaviour:
- State machine, states IDLE, FETCH, HALTED; reset state IDLE.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH -> HALTED when id_halt & valid_o & !stall.
- HALTED is left only by reset.
- iREN = (state==FETCH).
- halted = (state==HALTED).
- Reset values, applied asynchronously on nRST low: PC=PC_INIT, instr_o=NOP_WORD, npc_o=0, valid_o=0, state IDLE; hence iREN=0, imemaddr=PC_INIT, halted=0.
- taken = valid_o & !stall & (PCsrc==2 | PCsrc==3 | (PCsrc==4 & !zero) | (PCsrc==5 & zero)).
- Redirect target by PCsrc:
  - 2: rdat1
  - 3: {npc_o[31:28], jaddr, 2'b00}
  - 4/5: branch_tgt
- PC update in FETCH, priority order:
  1. taken: PC <= target, regardless of ihit; an outstanding fetch is abandoned and the next cycle requests the new address.
  2. stall: PC holds.
  3. ihit: PC <= PC+4, 32-bit wrap-around with no overflow flag.
  4. otherwise: PC holds.
- PC holds in IDLE and HALTED.
- IF/ID update, priority order:
  1. state!=FETCH: hold; on entry to HALTED it is loaded with the bubble.
  2. flush | taken: instr_o=NOP_WORD, valid_o=0, npc_o unchanged. The wrong-path word returned this cycle is discarded.
  3. stall: hold all three.
  4. ihit: instr_o=imemload_in, npc_o=PC+4, valid_o=1.
  5. otherwise (miss, not stalled): bubble.
- Latency: an instruction is visible at instr_o the cycle after its ihit. A sustained ihit gives one instruction per cycle.
- Simultaneous events:
  - stall & flush: flush wins for IF/ID; PC holds.
  - taken requires !stall, so redirect and stall never coexist.
  - id_halt with stall: ignored until stall drops.
- Reset mid-miss: state returns to IDLE, and any later ihit for the old address is ignored because iREN=0 until FETCH.

Decomposition:
- cpu_types_pkg gains:
  - a pcsrc_t enum (PC_NPC=0, PC_JR=2, PC_J=3, PC_BNE=4, PC_BEQ=5).
  - a fetch_state_t enum.
  - a NOP_INSTR constant.
- Matching fetch_unit_if interface file with fu (block) and tb modports.
- One natural sub-module, pc_next_sel: combinational taken/target logic, unit-testable alone.

Test Plan:
- Reset, then ihit held high with words A,B,C: IDLE for one cycle, then imemaddr 0,4,8. instr_o=A one cycle after the first ihit, npc_o=4, valid_o=1.
- ihit low for 3 cycles at PC=8: PC stays 8, iREN=1, valid_o=0 and instr_o=0 for those cycles. On ihit, PC becomes 12.
- valid_o=1, PCsrc=5, zero=1, branch_tgt=0x40, ihit=1: next PC=0x40, IF/ID bubbled. With zero=0 there is no redirect and PC advances by 4.
- PCsrc=3, npc_o=0x1000_0008, jaddr=26'h10: PC becomes 0x1000_0040. PCsrc=2 with rdat1=0x80: PC becomes 0x80.
- stall=1 for 2 cycles with ihit=1: PC, instr_o, npc_o and valid_o frozen. stall & flush together: valid_o=0.
- id_halt=1 with valid_o=1: next cycle halted=1, iREN=0, PC frozen indefinitely. nRST pulse mid-miss: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared encodings for the fetch stage and its neighbours
package cpu_types_pkg;
  typedef enum logic [2:0] {
    PC_NPC = 3'd0,
    PC_JR  = 3'd2,
    PC_J   = 3'd3,
    PC_BNE = 3'd4,
    PC_BEQ = 3'd5
  } pcsrc_t;
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache, decode-feedback and IF/ID signals of the fetch stage
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] imemload_in;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        flush;
  logic [2:0]  PCsrc;
  logic        zero;
  logic [31:0] rdat1;
  logic [31:0] branch_tgt;
  logic [25:0] jaddr;
  logic        id_halt;
  logic [31:0] instr_o;
  logic [31:0] npc_o;
  logic        valid_o;
  logic        halted;
  modport fu (
    input  ihit, imemload_in, stall, flush, PCsrc, zero, rdat1, branch_tgt, jaddr, id_halt,
    output iREN, imemaddr, instr_o, npc_o, valid_o, halted
  );
  modport tb (
    output ihit, imemload_in, stall, flush, PCsrc, zero, rdat1, branch_tgt, jaddr, id_halt,
    input  iREN, imemaddr, instr_o, npc_o, valid_o, halted
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: decides whether decode redirects the PC and to which address
module pc_next_sel
  import cpu_types_pkg::*;
(
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic [2:0]  i_pcsrc,
  input  logic        i_zero,
  input  logic [31:0] i_rdat1,
  input  logic [31:0] i_branch_tgt,
  input  logic [25:0] i_jaddr,
  input  logic [31:0] i_npc,
  output logic        o_taken,
  output logic [31:0] o_target
);
  logic w_redirect;
  // only a real, unstalled instruction in IF/ID may redirect; unused encodings fall through to npc
  always_comb begin
    w_redirect = (i_pcsrc == PC_JR) | (i_pcsrc == PC_J)
               | ((i_pcsrc == PC_BNE) & !i_zero) | ((i_pcsrc == PC_BEQ) & i_zero);
    o_taken    = i_valid & !i_stall & w_redirect;
    o_target   = (i_pcsrc == PC_JR) ? i_rdat1
               : (i_pcsrc == PC_J)  ? {i_npc[31:28], i_jaddr, 2'b00}
               : i_branch_tgt;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, icache requester and IF/ID register of the pipeline
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input logic      CLK,
  input logic      nRST,
  fetch_unit_if.fu fif
);
  localparam logic [1:0] ST_IDLE   = FS_IDLE;
  localparam logic [1:0] ST_FETCH  = FS_FETCH;
  localparam logic [1:0] ST_HALTED = FS_HALTED;
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;
  logic        w_fetch;
  logic        w_halt;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  assign w_fetch = (r_state == ST_FETCH);
  assign w_halt  = w_fetch & fif.id_halt & r_valid & !fif.stall;
  assign w_pc4   = r_pc + 32'd4;
  pc_next_sel u_sel (
    .i_valid     (r_valid),
    .i_stall     (fif.stall),
    .i_pcsrc     (fif.PCsrc),
    .i_zero      (fif.zero),
    .i_rdat1     (fif.rdat1),
    .i_branch_tgt(fif.branch_tgt),
    .i_jaddr     (fif.jaddr),
    .i_npc       (r_npc),
    .o_taken     (w_taken),
    .o_target    (w_target)
  );
  // start fetching one cycle after reset; a committed halt is only undone by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else if (r_state == ST_IDLE) r_state <= ST_FETCH;
    else if (w_halt) r_state <= ST_HALTED;
  end
  // redirect beats stall, a hit advances; an abandoned fetch simply re-requests at the target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_pc <= PC_INIT;
    else if (w_fetch) r_pc <= w_taken ? w_target : fif.stall ? r_pc : fif.ihit ? w_pc4 : r_pc;
  end
  // IF/ID: bubble on halt entry, flush or redirect; freeze on stall; otherwise capture a hit or bubble a miss
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr <= NOP_WORD;
      r_npc   <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_fetch) begin
      if (w_halt | fif.flush | w_taken) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (!fif.stall) begin
        r_instr <= fif.ihit ? fif.imemload_in : NOP_WORD;
        r_valid <= fif.ihit;
        if (fif.ihit) r_npc <= w_pc4;
      end
    end
  end
  assign fif.iREN     = w_fetch;
  assign fif.imemaddr = r_pc;
  assign fif.instr_o  = r_instr;
  assign fif.npc_o    = r_npc;
  assign fif.valid_o  = r_valid;
  assign fif.halted   = (r_state == ST_HALTED);
endmodule
